// File: rtl/apu_waveform_generator.sv
// apu_waveform_generator
//   Converts the phase accumulator output into an 8-bit unsigned channel
//   sample. Supported waveforms are pulse (four duties), triangle, sawtooth
//   and 15-bit LFSR noise. The level is scaled by a 4-bit volume and muted
//   by a length counter that counts period wraps. Configuration is
//   double-buffered and only becomes active at a period boundary, or at
//   any time while the channel is muted.
//
// Ports
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_phase           32-bit phase word; the step index is i_phase[31:27]
//   i_phase_strobe    one-cycle pulse on each period wrap
//   i_cfg_wave        0 pulse, 1 triangle, 2 sawtooth, 3 noise
//   i_cfg_duty        pulse duty: 0 12.5%, 1 25%, 2 50%, 3 75%
//   i_cfg_volume      amplitude scale 0..15
//   i_cfg_valid       writes wave/duty/volume into the pending config
//   i_length          length counter load value, in period wraps
//   i_length_load     loads the length counter (has priority over decrement)
//   i_length_halt     freezes the length counter while high
//   o_sample          level x volume, 0..225, two cycles after its phase
//   o_sample_valid    high from the second cycle after reset release
//   o_active          length counter nonzero
module apu_waveform_generator #(
    parameter logic [14:0] LFSR_SEED = 15'h0001
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_phase,
    input  logic        i_phase_strobe,
    input  logic [1:0]  i_cfg_wave,
    input  logic [1:0]  i_cfg_duty,
    input  logic [3:0]  i_cfg_volume,
    input  logic        i_cfg_valid,
    input  logic [7:0]  i_length,
    input  logic        i_length_load,
    input  logic        i_length_halt,
    output logic [7:0]  o_sample,
    output logic        o_sample_valid,
    output logic        o_active
);

    typedef enum logic [1:0] {
        WAVE_PULSE    = 2'd0,
        WAVE_TRIANGLE = 2'd1,
        WAVE_SAWTOOTH = 2'd2,
        WAVE_NOISE    = 2'd3
    } wave_t;

    wave_t       pend_wave, act_wave;
    logic [1:0]  pend_duty, act_duty;
    logic [3:0]  pend_vol,  act_vol;

    logic [7:0]  len, len_next;
    logic [14:0] lfsr;
    logic        copy_cfg;

    logic [4:0]  step_idx;
    logic [3:0]  duty_thresh;
    logic [3:0]  level;
    logic [3:0]  s1_level, s1_vol;
    logic        primed;
    logic        unused_phase_bits;

    always_comb begin
        step_idx          = i_phase[31:27];
        unused_phase_bits = ^i_phase[26:0];
        copy_cfg          = i_phase_strobe || (len == 8'd0);
    end

    always_comb begin
        len_next = len;
        if (i_length_load) begin
            len_next = i_length;
        end else if (i_phase_strobe && !i_length_halt && (len != 8'd0)) begin
            len_next = len - 8'd1;
        end
    end

    always_comb begin
        duty_thresh = 4'd4;
        case (act_duty)
            2'd0: duty_thresh = 4'd1;
            2'd1: duty_thresh = 4'd2;
            2'd2: duty_thresh = 4'd4;
            2'd3: duty_thresh = 4'd6;
            default: duty_thresh = 4'd4;
        endcase
    end

    // Muting looks at the post-update count, so a load of 0 or the final
    // decrementing strobe silences the sample taken in that same cycle.
    always_comb begin
        level = '0;
        case (act_wave)
            WAVE_PULSE:    level = ({1'b0, step_idx[4:2]} < duty_thresh) ? 4'hF : 4'h0;
            WAVE_TRIANGLE: level = step_idx[4] ? step_idx[3:0] : ~step_idx[3:0];
            WAVE_SAWTOOTH: level = step_idx[4:1];
            WAVE_NOISE:    level = lfsr[0] ? 4'h0 : 4'hF;
            default:       level = '0;
        endcase
        if (len_next == 8'd0) begin
            level = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_wave      <= WAVE_PULSE;
            pend_duty      <= 2'd2;
            pend_vol       <= '0;
            act_wave       <= WAVE_PULSE;
            act_duty       <= 2'd2;
            act_vol        <= '0;
            len            <= '0;
            lfsr           <= LFSR_SEED;
            s1_level       <= '0;
            s1_vol         <= '0;
            o_sample       <= '0;
            o_active       <= 1'b0;
            primed         <= 1'b0;
            o_sample_valid <= 1'b0;
        end else begin
            if (i_cfg_valid) begin
                pend_wave <= wave_t'(i_cfg_wave);
                pend_duty <= i_cfg_duty;
                pend_vol  <= i_cfg_volume;
            end
            // A write coinciding with the copy condition bypasses pending.
            if (copy_cfg) begin
                if (i_cfg_valid) begin
                    act_wave <= wave_t'(i_cfg_wave);
                    act_duty <= i_cfg_duty;
                    act_vol  <= i_cfg_volume;
                end else begin
                    act_wave <= pend_wave;
                    act_duty <= pend_duty;
                    act_vol  <= pend_vol;
                end
            end

            if (i_phase_strobe) begin
                lfsr <= {lfsr[0] ^ lfsr[1], lfsr[14:1]};
            end

            len      <= len_next;
            o_active <= (len_next != 8'd0);

            s1_level <= level;
            s1_vol   <= act_vol;
            o_sample <= {4'b0000, s1_level} * {4'b0000, s1_vol};

            primed         <= 1'b1;
            o_sample_valid <= primed;
        end
    end

endmodule

// File: tb/tb_apu_waveform_generator.sv
module tb_apu_waveform_generator;

    logic        clk;
    logic        rst;
    logic [31:0] phase;
    logic        strobe;
    logic [1:0]  cfg_wave;
    logic [1:0]  cfg_duty;
    logic [3:0]  cfg_volume;
    logic        cfg_valid;
    logic [7:0]  length;
    logic        length_load;
    logic        length_halt;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        active;

    int tests  = 0;
    int failed = 0;

    apu_waveform_generator #(.LFSR_SEED(15'h0001)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_phase        (phase),
        .i_phase_strobe (strobe),
        .i_cfg_wave     (cfg_wave),
        .i_cfg_duty     (cfg_duty),
        .i_cfg_volume   (cfg_volume),
        .i_cfg_valid    (cfg_valid),
        .i_length       (length),
        .i_length_load  (length_load),
        .i_length_halt  (length_halt),
        .o_sample       (sample),
        .o_sample_valid (sample_valid),
        .o_active       (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p(input logic [4:0] p);
        phase = {p, 27'h2AAAAAA};
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic [1:0] d, input logic [3:0] v);
        cfg_wave   = w;
        cfg_duty   = d;
        cfg_volume = v;
        cfg_valid  = 1'b1;
    endtask

    task automatic hold_check(input logic [4:0] p, input logic [7:0] exp, input string tag);
        set_p(p);
        step();
        step();
        check(tag, {24'd0, sample}, {24'd0, exp});
    endtask

    initial begin
        rst = 1'b1; phase = '0; strobe = 1'b0;
        cfg_wave = '0; cfg_duty = '0; cfg_volume = '0; cfg_valid = 1'b0;
        length = '0; length_load = 1'b0; length_halt = 1'b0;
        step();
        step();
        check("rst_sample", {24'd0, sample}, 32'd0);
        check("rst_active", {31'd0, active}, 32'd0);
        check("rst_valid",  {31'd0, sample_valid}, 32'd0);
        check("rst_lfsr",   {17'd0, dut.lfsr}, 32'h0001);

        rst = 1'b0;
        check("valid_n0", {31'd0, sample_valid}, 32'd0);
        step();
        check("valid_n1", {31'd0, sample_valid}, 32'd0);
        step();
        check("valid_n2", {31'd0, sample_valid}, 32'd1);

        // Noise: configure while muted, so it goes straight to active.
        set_cfg(2'd3, 2'd2, 4'd15);
        length = 8'd5; length_load = 1'b1;
        set_p(5'd0);
        step();
        cfg_valid = 1'b0; length_load = 1'b0;
        step();
        step();
        check("noise_seed_sample", {24'd0, sample}, 32'd0);
        check("noise_active", {31'd0, active}, 32'd1);
        strobe = 1'b1; step(); strobe = 1'b0;
        check("noise_lfsr1", {17'd0, dut.lfsr}, 32'h4000);
        step(); step();
        check("noise_s1", {24'd0, sample}, 32'd225);
        strobe = 1'b1; step(); strobe = 1'b0;
        check("noise_lfsr2", {17'd0, dut.lfsr}, 32'h2000);
        step(); step();
        check("noise_s2", {24'd0, sample}, 32'd225);
        strobe = 1'b1; step(); strobe = 1'b0;
        check("noise_lfsr3", {17'd0, dut.lfsr}, 32'h1000);
        step(); step();
        check("noise_s3", {24'd0, sample}, 32'd225);

        // Pulse sweep, duty 50%, one phase step per cycle.
        set_cfg(2'd0, 2'd2, 4'd15);
        length = 8'd10; length_load = 1'b1; strobe = 1'b1;
        step();
        cfg_valid = 1'b0; length_load = 1'b0; strobe = 1'b0;
        for (int unsigned k = 0; k <= 32; k++) begin
            if (k < 32) set_p(5'(k));
            step();
            if (k >= 1) begin
                check($sformatf("pulse_p%0d", k - 1), {24'd0, sample},
                      (k - 1 < 16) ? 32'd225 : 32'd0);
            end
        end
        check("pulse_active", {31'd0, active}, 32'd1);

        // Triangle, applied at a strobe.
        set_cfg(2'd1, 2'd2, 4'd15); strobe = 1'b1;
        step();
        cfg_valid = 1'b0; strobe = 1'b0;
        hold_check(5'd0,  8'd225, "tri_p0");
        hold_check(5'd15, 8'd0,   "tri_p15");
        hold_check(5'd16, 8'd0,   "tri_p16");
        hold_check(5'd31, 8'd225, "tri_p31");
        set_cfg(2'd1, 2'd2, 4'd8); strobe = 1'b1;
        step();
        cfg_valid = 1'b0; strobe = 1'b0;
        hold_check(5'd0, 8'd120, "tri_vol8_p0");

        // Length counter runs out after 3 strobes.
        length = 8'd3; length_load = 1'b1;
        step();
        length_load = 1'b0;
        check("len_active_loaded", {31'd0, active}, 32'd1);
        for (int unsigned i = 0; i < 3; i++) begin
            strobe = 1'b1; step(); strobe = 1'b0;
            if (i < 2) step();
        end
        check("len_active_fall", {31'd0, active}, 32'd0);
        check("len_sample_before_mute", {24'd0, sample}, 32'd120);
        step();
        check("len_sample_muted", {24'd0, sample}, 32'd0);

        // Same again with halt: nothing decrements.
        length = 8'd3; length_load = 1'b1; length_halt = 1'b1;
        step();
        length_load = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            strobe = 1'b1; step(); strobe = 1'b0; step();
        end
        step();
        check("halt_active", {31'd0, active}, 32'd1);
        check("halt_sample", {24'd0, sample}, 32'd120);
        length_halt = 1'b0;

        // Load coincident with a strobe keeps the loaded value.
        length = 8'd2; length_load = 1'b1; strobe = 1'b1;
        step();
        length_load = 1'b0; strobe = 1'b0;
        check("coinc_active0", {31'd0, active}, 32'd1);
        strobe = 1'b1; step(); strobe = 1'b0;
        check("coinc_active1", {31'd0, active}, 32'd1);
        strobe = 1'b1; step(); strobe = 1'b0;
        check("coinc_active2", {31'd0, active}, 32'd0);

        // Deferred config: duty change waits for the next strobe.
        set_cfg(2'd0, 2'd2, 4'd15);
        length = 8'd10; length_load = 1'b1;
        step();
        cfg_valid = 1'b0; length_load = 1'b0;
        set_p(5'd4);
        set_cfg(2'd0, 2'd0, 4'd15);
        step();
        cfg_valid = 1'b0;
        step();
        check("defer_write_cycle", {24'd0, sample}, 32'd225);
        step();
        check("defer_pending", {24'd0, sample}, 32'd225);
        strobe = 1'b1; step(); strobe = 1'b0;
        step();
        check("defer_strobe_cycle", {24'd0, sample}, 32'd225);
        step();
        check("defer_applied_p4", {24'd0, sample}, 32'd0);
        hold_check(5'd3,  8'd225, "duty0_p3");
        hold_check(5'd31, 8'd0,   "duty0_p31");
        hold_check(5'd3,  8'd225, "duty0_p3_again");
        check("pre_reset_active", {31'd0, active}, 32'd1);

        // One-cycle reset in mid-stream.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_sample", {24'd0, sample}, 32'd0);
        check("midrst_active", {31'd0, active}, 32'd0);
        check("midrst_valid",  {31'd0, sample_valid}, 32'd0);
        check("midrst_lfsr",   {17'd0, dut.lfsr}, 32'h0001);
        step();
        check("midrst_valid_n1", {31'd0, sample_valid}, 32'd0);
        step();
        check("midrst_valid_n2", {31'd0, sample_valid}, 32'd1);
        check("midrst_sample_n2", {24'd0, sample}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/apu_waveform_generator.md
# apu_waveform_generator

Downstream consumer of the phase accumulator in the audio path. Turns the 32-bit phase word and its wrap strobe into an 8-bit unsigned channel sample. Supports pulse (4 duties), triangle, sawtooth and LFSR noise. Includes a 4-bit volume multiply and a wrap-counted length counter that mutes the channel. Configuration is double-buffered so waveform changes only take effect at a period boundary.

## Interface
Parameters:
- LFSR_SEED, 15'h0001: noise LFSR reset/seed value; must be nonzero.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, synchronous, active-high
- i_phase  input  32  phase word from the accumulator, updates every clock
- i_phase_strobe  input  1  accumulator carry; high for one cycle per period wrap
- i_cfg_wave  input  2  waveform select: 0 pulse, 1 triangle, 2 sawtooth, 3 noise
- i_cfg_duty  input  2  pulse duty: 0 12.5%, 1 25%, 2 50%, 3 75%
- i_cfg_volume  input  4  amplitude scale, 0..15
- i_cfg_valid  input  1  load wave/duty/volume into the pending config
- i_length  input  8  length counter load value, in period wraps
- i_length_load  input  1  load length counter
- i_length_halt  input  1  freeze length counter while high
- o_sample  output  8  unsigned sample, level × volume, 0..225
- o_sample_valid  output  1  pipeline primed; high from the second cycle after reset release
- o_active  output  1  length counter nonzero

## Operation
- Step index p = i_phase[31:27], 0..31.
- The 4-bit level L is selected by the active config:
  - pulse: L = 15 if p[4:2] < D, else 0; D = 1, 2, 4, 6 for duty 0..3.
  - triangle: L = p[4] ? p[3:0] : ~p[3:0]. Gives 15 down to 0, then 0 up to 15.
  - sawtooth: L = p[4:1].
  - noise: L = lfsr[0] ? 0 : 15.
- Force L = 0 when the length counter is 0.
- Sample = L × active_volume, an unsigned 4×4 → 8-bit product with no saturation needed.
- Config path:
  - i_cfg_valid writes the pending register every time.
  - Pending copies into active at the end of any cycle where i_phase_strobe = 1 or the length counter = 0.
  - If i_cfg_valid and the copy condition fall in the same cycle, the new input values go straight to active.
- Noise LFSR, 15 bits:
  - Steps at the end of each i_phase_strobe cycle, regardless of the selected wave.
  - Step rule: fb = lfsr[0] ^ lfsr[1]; lfsr <= {fb, lfsr[14:1]}.
- Length counter, 8 bits:
  - i_length_load has priority and loads i_length. Loading 0 mutes immediately.
  - Otherwise it decrements on i_phase_strobe when nonzero and i_length_halt = 0.
  - It holds at 0; no wrap below 0.
- Reset values:
  - o_sample 0, o_sample_valid 0, o_active 0, length 0, lfsr LFSR_SEED.
  - Pending and active config: wave 0, duty 2, volume 0.
- Reset mid-operation: all state returns to reset values on the next edge. No partial sample is emitted.

## Timing
- Two-stage pipeline:
  - Stage 1 registers L and volume from the phase and active config of cycle N.
  - Stage 2 registers the product.
  - o_sample reflects the cycle-N phase at cycle N+2.
- A config write in cycle N:
  - Active from cycle N+1 if the copy condition holds in cycle N. Visible on o_sample from N+3.
  - Otherwise waits for the next strobe.
  - The cycle carrying the strobe still uses the old config.
- o_active is registered from the length counter. It falls in the cycle after the decrementing strobe. o_sample reaches 0 one cycle after that.
- o_sample_valid is 0 in cycles N+0 and N+1 after reset release, and 1 thereafter.

## Test plan
- Pulse sweep: wave 0, duty 2, volume 15, length 10.
  - Drive p = 0..31 one per cycle with no strobe.
  - o_sample = 225 for p 0..15 and 0 for 16..31, each 2 cycles after its phase.
- Triangle: wave 1, volume 15 → p 0/15/16/31 give 225/0/0/225. Volume 8 at p = 0 gives 120.
- Noise from reset, wave 0 → 3 during mute, volume 15:
  - Load length 5.
  - The first sample before any strobe is 0 (lfsr 0x0001).
  - Strobes give lfsr 0x4000, 0x2000, 0x1000, each yielding 225.
- Length: load 3, then 3 strobes.
  - o_active falls the cycle after the 3rd strobe; o_sample is 0 one cycle later.
  - Repeat with i_length_halt = 1: o_active stays 1.
  - Load coincident with a strobe: the loaded value is kept, not decremented.
- Deferred config: active pulse at duty 2; write duty 0 at p = 4.
  - Samples keep duty 2 until the next strobe, then p 4..31 read 0.
- Reset asserted mid-stream for 1 cycle:
  - Next cycle o_sample = 0, o_active = 0, o_sample_valid = 0, lfsr = LFSR_SEED.
